// File: rtl/reset_conditioner.sv
// Conditions a bouncy board switch and a raw FX3 reset into one clean, held
// active-low reset, and records the cause and count of run-to-reset events.
module reset_conditioner #(
    parameter int DEBOUNCE_CYCLES = 800_000,
    parameter int FILTER_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       BOARD_RST_SW,
    input  logic       SL_RST_N,
    output logic       RST_OUT_N,
    output logic [1:0] RST_CAUSE,
    output logic [7:0] RST_COUNT,
    output logic [1:0] STATE
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FL_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FILTER_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_HOLD  = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    logic            sw_meta_q, sw_s_q, sl_meta_q, sl_s_q;
    logic            sw_db_q, sw_db_d, sl_f_q, sl_f_d;
    logic [DB_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [FL_W-1:0] sl_cnt_q, sl_cnt_d;
    logic [HD_W-1:0] hold_q, hold_d;
    state_t          state_q, state_d;
    logic            rst_out_q, rst_out_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic            req;

    // Accept a new level only after an unbroken run of differing samples.
    always_comb begin
        sw_db_d  = sw_db_q;
        sw_cnt_d = '0;
        if (sw_s_q != sw_db_q) begin
            if (sw_cnt_q == DB_LAST) begin
                sw_db_d = sw_s_q;
            end else begin
                sw_cnt_d = sw_cnt_q + DB_W'(1);
            end
        end

        sl_f_d   = sl_f_q;
        sl_cnt_d = '0;
        if (sl_s_q != sl_f_q) begin
            if (sl_cnt_q == FL_LAST) begin
                sl_f_d = sl_s_q;
            end else begin
                sl_cnt_d = sl_cnt_q + FL_W'(1);
            end
        end
    end

    assign req = sw_db_q | ~sl_f_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            S_RESET: begin
                if (!req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            end
            S_HOLD: begin
                if (req) begin
                    state_d = S_RESET;
                    hold_d  = '0;
                end else if (hold_q == HD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HD_W'(1);
                end
            end
            S_RUN: begin
                if (req) begin
                    state_d = S_RESET;
                    cause_d = {sw_db_q, ~sl_f_q};
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
        // Registered so the output toggles on the same edge the state does.
        rst_out_d = (state_d == S_RUN);
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
            sl_meta_q <= 1'b0;
            sl_s_q    <= 1'b0;
            sw_db_q   <= 1'b0;
            sw_cnt_q  <= '0;
            sl_f_q    <= 1'b0;
            sl_cnt_q  <= '0;
            hold_q    <= '0;
            state_q   <= S_RESET;
            rst_out_q <= 1'b0;
            cause_q   <= 2'b00;
            count_q   <= 8'h00;
        end else begin
            sw_meta_q <= BOARD_RST_SW;
            sw_s_q    <= sw_meta_q;
            sl_meta_q <= SL_RST_N;
            sl_s_q    <= sl_meta_q;
            sw_db_q   <= sw_db_d;
            sw_cnt_q  <= sw_cnt_d;
            sl_f_q    <= sl_f_d;
            sl_cnt_q  <= sl_cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            rst_out_q <= rst_out_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    assign RST_OUT_N = rst_out_q;
    assign RST_CAUSE = cause_q;
    assign RST_COUNT = count_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner with short debounce/filter/hold settings.
module tb_reset_conditioner;

    logic       clk;
    logic       sys_rst_n;
    logic       board_sw;
    logic       sl_rst_n;
    logic       rst_out_n;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;
    logic [1:0] state;

    int tests;
    int failed;

    reset_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .FILTER_CYCLES  (4),
        .HOLD_CYCLES    (16)
    ) dut (
        .SYS_CLK     (clk),
        .SYS_RST_N   (sys_rst_n),
        .BOARD_RST_SW(board_sw),
        .SL_RST_N    (sl_rst_n),
        .RST_OUT_N   (rst_out_n),
        .RST_CAUSE   (rst_cause),
        .RST_COUNT   (rst_count),
        .STATE       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns 1 ns after the n-th rising edge from now.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        sys_rst_n = 1'b0;
        board_sw  = 1'b0;
        sl_rst_n  = 1'b1;

        // Held in reset
        step(3);
        check("rst_out_in_reset", {7'd0, rst_out_n}, 8'h00);
        check("state_in_reset",   {6'd0, state},     8'h00);
        check("count_in_reset",   rst_count,         8'h00);
        check("cause_in_reset",   {6'd0, rst_cause}, 8'h00);

        // Power-up release: next rising edge is edge 0
        sys_rst_n = 1'b1;
        step(6);
        check("pu_state_e5",  {6'd0, state}, 8'h00);
        step(1);
        check("pu_state_e6",  {6'd0, state}, 8'h01);
        step(15);
        check("pu_state_e21", {6'd0, state}, 8'h01);
        check("pu_rst_e21",   {7'd0, rst_out_n}, 8'h00);
        step(1);
        check("pu_state_e22", {6'd0, state}, 8'h02);
        check("pu_rst_e22",   {7'd0, rst_out_n}, 8'h01);
        check("pu_count",     rst_count, 8'h00);
        check("pu_cause",     {6'd0, rst_cause}, 8'h00);

        // SL_RST_N glitch of 3 cycles is filtered out
        sl_rst_n = 1'b0;
        step(3);
        sl_rst_n = 1'b1;
        step(10);
        check("glitch3_rst",   {7'd0, rst_out_n}, 8'h01);
        check("glitch3_state", {6'd0, state}, 8'h02);
        check("glitch3_count", rst_count, 8'h00);

        // SL_RST_N held low: reset at edge 6
        sl_rst_n = 1'b0;
        step(6);
        check("sl_rst_e5", {7'd0, rst_out_n}, 8'h01);
        step(1);
        check("sl_rst_e6", {7'd0, rst_out_n}, 8'h00);
        check("sl_cause",  {6'd0, rst_cause}, 8'h01);
        check("sl_count",  rst_count, 8'h01);
        sl_rst_n = 1'b1;
        step(22);
        check("sl_rel_e21", {7'd0, rst_out_n}, 8'h00);
        step(1);
        check("sl_rel_e22", {7'd0, rst_out_n}, 8'h01);

        // Switch bounce then held: reset 10 edges after stable level sampled
        board_sw = 1'b1; step(1);
        board_sw = 1'b0; step(1);
        board_sw = 1'b1; step(1);
        board_sw = 1'b0; step(1);
        board_sw = 1'b1;
        step(10);
        check("sw_rst_e9",  {7'd0, rst_out_n}, 8'h01);
        step(1);
        check("sw_rst_e10", {7'd0, rst_out_n}, 8'h00);
        check("sw_cause",   {6'd0, rst_cause}, 8'h02);
        check("sw_count",   rst_count, 8'h02);
        board_sw = 1'b0;
        step(26);
        check("sw_rel_e25", {7'd0, rst_out_n}, 8'h00);
        step(1);
        check("sw_rel_e26", {7'd0, rst_out_n}, 8'h01);

        // Reassertion during hold restarts the full hold interval
        sl_rst_n = 1'b0;
        step(7);
        check("hold_pre_rst",   {7'd0, rst_out_n}, 8'h00);
        check("hold_pre_count", rst_count, 8'h03);
        check("hold_pre_cause", {6'd0, rst_cause}, 8'h01);
        sl_rst_n = 1'b1;
        step(11);
        check("hold_entered", {6'd0, state}, 8'h01);
        sl_rst_n = 1'b0;
        step(4);
        sl_rst_n = 1'b1;
        step(2);
        check("hold_cnt10_state", {6'd0, state}, 8'h01);
        step(1);
        check("hold_abort_state", {6'd0, state}, 8'h00);
        check("hold_abort_count", rst_count, 8'h03);
        check("hold_abort_cause", {6'd0, rst_cause}, 8'h01);
        step(3);
        check("hold_r5_state", {6'd0, state}, 8'h00);
        step(1);
        check("hold_r6_state", {6'd0, state}, 8'h01);
        step(15);
        check("hold_r21_state", {6'd0, state}, 8'h01);
        check("hold_r21_rst",   {7'd0, rst_out_n}, 8'h00);
        step(1);
        check("hold_r22_state", {6'd0, state}, 8'h02);
        check("hold_r22_rst",   {7'd0, rst_out_n}, 8'h01);
        check("hold_r22_count", rst_count, 8'h03);

        // 300 run-to-reset events saturate the counter
        for (int i = 0; i < 300; i++) begin
            sl_rst_n = 1'b0;
            step(7);
            sl_rst_n = 1'b1;
            step(23);
            if (i == 99) check("sat_count_mid", rst_count, 8'h67);
        end
        check("sat_count", rst_count, 8'hFF);
        check("sat_rst",   {7'd0, rst_out_n}, 8'h01);
        check("sat_state", {6'd0, state}, 8'h02);

        // Asynchronous SYS_RST_N pulse in S_RUN
        sys_rst_n = 1'b0;
        #1;
        check("async_rst",   {7'd0, rst_out_n}, 8'h00);
        check("async_state", {6'd0, state}, 8'h00);
        check("async_count", rst_count, 8'h00);
        check("async_cause", {6'd0, rst_cause}, 8'h00);
        #2;
        sys_rst_n = 1'b1;
        step(22);
        check("async_rel_e21", {7'd0, rst_out_n}, 8'h00);
        check("async_st_e21",  {6'd0, state}, 8'h01);
        step(1);
        check("async_rel_e22", {7'd0, rst_out_n}, 8'h01);
        check("async_st_e22",  {6'd0, state}, 8'h02);
        check("async_cnt_e22", rst_count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
